// File: rtl/dvi_pkg.sv
// Shared definitions for the DVI timing block: default 640x480@60 timing,
// sync polarities, FSM state encoding and pixel/counter widths.
package dvi_pkg;

   localparam int PIX_W = 24;
   localparam int CNT_W = 12;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;

   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam logic HS_POL_DEF = 1'b0;
   localparam logic VS_POL_DEF = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } dvi_state_t;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/video_axis_cnt.sv
// Wrap counter for one video axis (pixels or lines) with decode of the
// active and sync phases; phase order is active, front porch, sync, back porch.
module video_axis_cnt
   import dvi_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE_DEF,
   parameter int FP     = H_FP_DEF,
   parameter int SYNC   = H_SYNC_DEF,
   parameter int BP     = H_BP_DEF,
   parameter int W      = CNT_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         last,
   output logic         in_active,
   output logic         in_sync
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   localparam logic [W-1:0] LAST_V    = W'(TOTAL - 1);
   localparam logic [W-1:0] ACTIVE_V  = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_LO_V = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_HI_V = W'(ACTIVE + FP + SYNC);

   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= last ? '0 : cnt + W'(1);
      end
   end

   assign last      = (cnt == LAST_V);
   assign in_active = (cnt < ACTIVE_V);
   assign in_sync   = (cnt >= SYNC_LO_V) && (cnt < SYNC_HI_V);

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI/TMDS video timing controller: requests pixels one clock ahead of de and
// emits registered de/hsync/vsync with frame-granular start/stop.
module dvi_timing_ctrl
   import dvi_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic HS_POL   = HS_POL_DEF,
   parameter logic VS_POL   = VS_POL_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   output logic             pix_req,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_valid,
   output logic             de,
   output logic             hsync,
   output logic             vsync,
   output logic [PIX_W-1:0] rgb_out,
   output logic             frame_start,
   output logic             underflow,
   input  logic             clr_underflow
);

   dvi_state_t state;
   dvi_state_t state_nxt;

   logic             running;
   logic             frame_end;
   logic             frame_origin;
   logic             pix_missing;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_last;
   logic             v_last;
   logic             h_active;
   logic             v_active;
   logic             h_sync;
   logic             v_sync;

   assign running = (state != ST_IDLE);

   video_axis_cnt #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .W      (CNT_W)
   ) u_h_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (~running),
      .inc       (running),
      .cnt       (h_cnt),
      .last      (h_last),
      .in_active (h_active),
      .in_sync   (h_sync)
   );

   video_axis_cnt #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .W      (CNT_W)
   ) u_v_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (~running),
      .inc       (running & h_last),
      .cnt       (v_cnt),
      .last      (v_last),
      .in_active (v_active),
      .in_sync   (v_sync)
   );

   assign frame_end    = h_last & v_last;
   assign frame_origin = (h_cnt == '0) && (v_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A stop request only takes effect once the frame in flight has finished.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (en) state_nxt = ST_RUN;
         ST_RUN:   if (!en) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (en) begin
               state_nxt = ST_RUN;
            end else if (frame_end) begin
               state_nxt = ST_IDLE;
            end
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign pix_req = running & h_active & v_active;
   assign pix_x   = pix_req ? h_cnt : '0;
   assign pix_y   = pix_req ? v_cnt : '0;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         de          <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         frame_start <= 1'b0;
      end else begin
         de          <= pix_req;
         hsync       <= (running && h_sync) ? HS_POL : ~HS_POL;
         vsync       <= (running && v_sync) ? VS_POL : ~VS_POL;
         frame_start <= running && frame_origin;
      end
   end

   // Returned pixel data lands in the same cycle as the registered de, so the
   // output mux gates it directly rather than adding another pipeline stage.
   assign pix_missing = de & ~pix_valid;
   assign rgb_out     = (de && pix_valid) ? pix_data : '0;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         underflow <= 1'b0;
      end else begin
         underflow <= pix_missing | (underflow & ~clr_underflow);
      end
   end

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Self-checking bench for dvi_timing_ctrl on a reduced 8x6 timing: a pixel
// source echoes x+256*y and a scoreboard checks rgb_out on every de cycle.
module tb_dvi_timing_ctrl;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en;
   logic        pix_req;
   logic [11:0] pix_x;
   logic [11:0] pix_y;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        de;
   logic        hsync;
   logic        vsync;
   logic [23:0] rgb_out;
   logic        frame_start;
   logic        underflow;
   logic        clr_underflow;

   int          n_tests = 0;
   int          n_fail = 0;
   int          n_popped = 0;
   bit          mon_on = 1'b0;
   bit          drop_en = 1'b0;
   int          drop_x = 0;
   int          drop_y = 0;
   logic [23:0] sb_q[$];

   dvi_timing_ctrl #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .HS_POL   (1'b0), .VS_POL (1'b0)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .en            (en),
      .pix_req       (pix_req),
      .pix_x         (pix_x),
      .pix_y         (pix_y),
      .pix_data      (pix_data),
      .pix_valid     (pix_valid),
      .de            (de),
      .hsync         (hsync),
      .vsync         (vsync),
      .rgb_out       (rgb_out),
      .frame_start   (frame_start),
      .underflow     (underflow),
      .clr_underflow (clr_underflow)
   );

   always #5 clk = ~clk;

   // Pixel source: answers each request one clock later; outside requests it
   // toggles pix_valid with junk data, which the DUT must ignore.
   initial begin : source
      logic        cur_req;
      logic [11:0] cx;
      logic [11:0] cy;
      logic        miss;
      logic        tog;
      logic [23:0] value;
      pix_data  = '0;
      pix_valid = 1'b0;
      tog       = 1'b0;
      forever begin
         @(negedge clk);
         cur_req = pix_req;
         cx      = pix_x;
         cy      = pix_y;
         @(posedge clk);
         #1;
         tog   = ~tog;
         miss  = drop_en && (cur_req === 1'b1) && (int'(cx) == drop_x) && (int'(cy) == drop_y);
         value = 24'(cx) + 24'(cy) * 24'd256;
         if (cur_req === 1'b1) begin
            pix_data  = value;
            pix_valid = ~miss;
         end else begin
            pix_data  = 24'h5A5A5A;
            pix_valid = tog;
         end
         if (rstn !== 1'b1) begin
            sb_q.delete();
         end else if (cur_req === 1'b1) begin
            sb_q.push_back(miss ? 24'h000000 : value);
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic [23:0] exp_rgb;
      if (mon_on) begin
         if (de === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL sb_empty: de=1 with no pending request, rgb_out=%h", rgb_out);
            end else begin
               exp_rgb = sb_q.pop_front();
               n_popped++;
               if (rgb_out !== exp_rgb) begin
                  n_fail++;
                  $display("[TB] FAIL sb_rgb: got %h expected %h", rgb_out, exp_rgb);
               end
            end
         end else begin
            n_tests++;
            if (rgb_out !== 24'h0) begin
               n_fail++;
               $display("[TB] FAIL rgb_blank: got %h expected 000000 (de=%b)", rgb_out, de);
            end
         end
      end
   end

   task automatic wait_frame_start(input int budget, input string tag, output int cycles);
      bit found;
      found  = 1'b0;
      cycles = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cycles = i + 1;
         if (frame_start === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("[TB] FAIL %s_fs_timeout: no frame_start within %0d clocks", tag, budget);
      end
   endtask

   // Walks n output cycles from a frame origin, comparing timing outputs with
   // positions derived from the sample index; en is dropped after sample en_off_at.
   task automatic sweep(input int n, input int en_off_at, input int frames, input bit first_wait,
                        input string tag);
      int         h, v, h1, v1;
      bit         on, on1;
      logic [4:0] exp_v, got_v;
      logic [23:0] exp_xy, got_xy;
      for (int k = 0; k < n; k++) begin
         if (k > 0 || first_wait) @(negedge clk);
         on  = k < frames * FRAME;
         on1 = (k + 1) < frames * FRAME;
         h   = (k % FRAME) % HT;
         v   = (k % FRAME) / HT;
         h1  = ((k + 1) % FRAME) % HT;
         v1  = ((k + 1) % FRAME) / HT;
         exp_v[4] = on && h < HA && v < VA;
         exp_v[3] = !(on && h >= HA + HF && h < HA + HF + HS);
         exp_v[2] = !(on && v >= VA + VF && v < VA + VF + VS);
         exp_v[1] = on && (k % FRAME == 0);
         exp_v[0] = on1 && h1 < HA && v1 < VA;
         got_v    = {de, hsync, vsync, frame_start, pix_req};
         n_tests++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s_timing k=%0d: {de,hs,vs,fs,req} got %b expected %b", tag, k, got_v, exp_v);
         end
         exp_xy = exp_v[0] ? {12'(h1), 12'(v1)} : 24'h0;
         got_xy = {pix_x, pix_y};
         n_tests++;
         if (got_xy !== exp_xy) begin
            n_fail++;
            $display("[TB] FAIL %s_xy k=%0d: {x,y} got %h expected %h", tag, k, got_xy, exp_xy);
         end
         if (k == en_off_at) en = 1'b0;
      end
   endtask

   task automatic test_reset();
      rstn          = 1'b0;
      en            = 1'b0;
      clr_underflow = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++; if (de !== 1'b0)          begin n_fail++; $display("[TB] FAIL rst_de: got %b expected 0", de); end
      n_tests++; if (hsync !== 1'b1)       begin n_fail++; $display("[TB] FAIL rst_hsync: got %b expected 1", hsync); end
      n_tests++; if (vsync !== 1'b1)       begin n_fail++; $display("[TB] FAIL rst_vsync: got %b expected 1", vsync); end
      n_tests++; if (rgb_out !== 24'h0)    begin n_fail++; $display("[TB] FAIL rst_rgb: got %h expected 0", rgb_out); end
      n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_fs: got %b expected 0", frame_start); end
      n_tests++; if (underflow !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_uf: got %b expected 0", underflow); end
      n_tests++; if (pix_req !== 1'b0)     begin n_fail++; $display("[TB] FAIL rst_req: got %b expected 0", pix_req); end
      rstn   = 1'b1;
      mon_on = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if ({de, frame_start, pix_req, hsync, vsync} !== 5'b00011) begin
            n_fail++;
            $display("[TB] FAIL idle_hold c=%0d: {de,fs,req,hs,vs} got %b expected 00011", i,
                     {de, frame_start, pix_req, hsync, vsync});
         end
      end
   endtask

   task automatic test_frame();
      int cyc;
      en = 1'b1;
      wait_frame_start(10, "frame", cyc);
      n_tests++;
      if (cyc != 2) begin
         n_fail++;
         $display("[TB] FAIL frame_latency: first frame_start after %0d clocks, expected 2", cyc);
      end
      sweep(2 * FRAME, -1, 99, 1'b0, "frame");
      n_tests++;
      if (underflow !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL frame_uf: got %b expected 0", underflow);
      end
   endtask

   task automatic test_pixels();
      int cyc;
      int p0;
      wait_frame_start(FRAME + 4, "pix", cyc);
      sweep(FRAME, -1, 99, 1'b0, "pix_a");
      p0 = n_popped;
      sweep(FRAME, -1, 99, 1'b1, "pix_b");
      n_tests++;
      if (n_popped - p0 != HA * VA) begin
         n_fail++;
         $display("[TB] FAIL pix_count: got %0d de cycles expected %0d", n_popped - p0, HA * VA);
      end
   endtask

   task automatic test_underflow();
      int cyc;
      wait_frame_start(FRAME + 4, "uf", cyc);
      drop_x  = 2;
      drop_y  = 1;
      drop_en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 10) begin
            n_tests++;
            if ({de, underflow} !== 2'b10) begin
               n_fail++;
               $display("[TB] FAIL uf_pre: {de,uf} got %b expected 10", {de, underflow});
            end
         end
         if (k == 11 || k == 20) begin
            n_tests++;
            if (underflow !== 1'b1) begin
               n_fail++;
               $display("[TB] FAIL uf_sticky k=%0d: got %b expected 1", k, underflow);
            end
         end
      end
      drop_en       = 1'b0;
      clr_underflow = 1'b1;
      @(negedge clk);
      clr_underflow = 1'b0;
      n_tests++;
      if (underflow !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL uf_clear: got %b expected 0", underflow);
      end
      // Set and clear in the same clock: the set must win for that clock.
      wait_frame_start(FRAME + 4, "uf2", cyc);
      drop_x        = 1;
      drop_y        = 2;
      drop_en       = 1'b1;
      clr_underflow = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k == 17 || k == 19) begin
            n_tests++;
            if (underflow !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL uf_clrhold k=%0d: got %b expected 0", k, underflow);
            end
         end
         if (k == 18) begin
            n_tests++;
            if (underflow !== 1'b1) begin
               n_fail++;
               $display("[TB] FAIL uf_setwins: got %b expected 1", underflow);
            end
         end
      end
      drop_en       = 1'b0;
      clr_underflow = 1'b0;
   endtask

   task automatic test_stop_restart();
      int cyc;
      wait_frame_start(FRAME + 4, "stop", cyc);
      sweep(FRAME + 16, 9, 1, 1'b0, "stop");
      en = 1'b1;
      wait_frame_start(10, "restart", cyc);
      n_tests++;
      if (cyc != 2) begin
         n_fail++;
         $display("[TB] FAIL restart_latency: got %0d clocks expected 2", cyc);
      end
      sweep(FRAME, -1, 99, 1'b0, "restart");
   endtask

   task automatic test_reset_mid();
      int cyc;
      wait_frame_start(FRAME + 4, "rmid", cyc);
      repeat (9) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({de, hsync, vsync, rgb_out, pix_req, frame_start} !== {1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL rmid_outputs: {de,hs,vs,rgb,req,fs} got %b %b %b %h %b %b expected 0 1 1 000000 0 0",
                  de, hsync, vsync, rgb_out, pix_req, frame_start);
      end
      rstn = 1'b1;
      wait_frame_start(10, "rmid_restart", cyc);
      n_tests++;
      if (cyc != 2) begin
         n_fail++;
         $display("[TB] FAIL rmid_latency: got %0d clocks expected 2", cyc);
      end
      sweep(FRAME, -1, 99, 1'b0, "rmid");
   endtask

   initial begin
      test_reset();
      test_frame();
      test_pixels();
      test_underflow();
      test_stop_restart();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
